// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use stall and branch/jump flush control.
// Define HAZARD_STATS_EN to add saturating StallCnt/FlushCnt statistics outputs.
module id_ex_stage_reg #(
  parameter int XLEN = 32
`ifdef HAZARD_STATS_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            RegWriteD,
  input  logic [1:0]      ResultSrcD,
  input  logic            MemWriteD,
  input  logic            JumpD,
  input  logic            BranchD,
  input  logic            ALUSrcD,
  input  logic [2:0]      ALUControlD,
  input  logic [XLEN-1:0] RD1_D,
  input  logic [XLEN-1:0] RD2_D,
  input  logic [XLEN-1:0] Imm_Ext_D,
  input  logic [XLEN-1:0] PCD,
  input  logic [XLEN-1:0] PCPlus4D,
  input  logic [4:0]      Rs1_D,
  input  logic [4:0]      Rs2_D,
  input  logic [4:0]      RD_D,
  input  logic            PCSrcE,
  output logic            RegWriteE,
  output logic            MemWriteE,
  output logic            JumpE,
  output logic            BranchE,
  output logic            ALUSrcE,
  output logic [1:0]      ResultSrcE,
  output logic [2:0]      ALUControlE,
  output logic [XLEN-1:0] RD1_E,
  output logic [XLEN-1:0] RD2_E,
  output logic [XLEN-1:0] Imm_Ext_E,
  output logic [XLEN-1:0] PCE,
  output logic [XLEN-1:0] PCPlus4E,
  output logic [4:0]      Rs1_E,
  output logic [4:0]      Rs2_E,
  output logic [4:0]      RD_E,
  output logic            ValidE,
  output logic            StallF,
  output logic            StallD,
  output logic            FlushD
`ifdef HAZARD_STATS_EN
  , output logic [CNT_W-1:0] StallCnt
  , output logic [CNT_W-1:0] FlushCnt
`endif
);

  localparam logic [1:0] RESULT_LOAD = 2'b01;

  typedef struct packed {
    logic            reg_write;
    logic [1:0]      result_src;
    logic            mem_write;
    logic            jump;
    logic            branch;
    logic            alu_src;
    logic [2:0]      alu_control;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            valid;
  } e_fields_t;

  e_fields_t e_q;
  e_fields_t d_word;
  logic      lw_stall;
  logic      stall;
  logic      flush_e;

  assign d_word = '{reg_write: RegWriteD, result_src: ResultSrcD, mem_write: MemWriteD,
                    jump: JumpD, branch: BranchD, alu_src: ALUSrcD, alu_control: ALUControlD,
                    rd1: RD1_D, rd2: RD2_D, imm: Imm_Ext_D, pc: PCD, pc_plus4: PCPlus4D,
                    rs1: Rs1_D, rs2: Rs2_D, rd: RD_D, valid: 1'b1};

  // A bubble has RD_E=0 and ValidE=0, so it can never trigger a second stall.
  assign lw_stall = e_q.valid && (e_q.result_src == RESULT_LOAD) && e_q.reg_write &&
                    (e_q.rd != 5'd0) && ((e_q.rd == Rs1_D) || (e_q.rd == Rs2_D));
  assign stall    = lw_stall && !PCSrcE;
  assign flush_e  = lw_stall || PCSrcE;

  assign StallF = rst && stall;
  assign StallD = rst && stall;
  assign FlushD = rst && PCSrcE;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      e_q <= '0;
    end else if (flush_e) begin
      e_q <= '0;
    end else begin
      e_q <= d_word;
    end
  end

  assign RegWriteE   = e_q.reg_write;
  assign ResultSrcE  = e_q.result_src;
  assign MemWriteE   = e_q.mem_write;
  assign JumpE       = e_q.jump;
  assign BranchE     = e_q.branch;
  assign ALUSrcE     = e_q.alu_src;
  assign ALUControlE = e_q.alu_control;
  assign RD1_E       = e_q.rd1;
  assign RD2_E       = e_q.rd2;
  assign Imm_Ext_E   = e_q.imm;
  assign PCE         = e_q.pc;
  assign PCPlus4E    = e_q.pc_plus4;
  assign Rs1_E       = e_q.rs1;
  assign Rs2_E       = e_q.rs2;
  assign RD_E        = e_q.rd;
  assign ValidE      = e_q.valid;

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      StallCnt <= '0;
      FlushCnt <= '0;
    end else begin
      if (stall && (StallCnt != '1)) StallCnt <= StallCnt + 1'b1;
      if (PCSrcE && (FlushCnt != '1)) FlushCnt <= FlushCnt + 1'b1;
    end
  end
`endif

endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
- Decode-to-execute pipeline register for the 5-stage RV32I core, with load-use hazard detection and branch/jump flush control.
- Captures decode-stage control and data every cycle.
- Drives the E-stage fields consumed by the execute datapath and forwarding logic (Rs1_E, Rs2_E, RD_E, RegWriteE).
- Generates StallF/StallD/FlushD for the fetch and decode registers; inserts bubbles into E on load-use stalls and taken branches.

Parameters:
- XLEN, 32, datapath width of RD1/RD2/Imm/PC fields
- CNT_W, 16, width of hazard statistics counters (used only with the optional feature)

Ports:
- clk  input  1  core clock, rising edge
- rst  input  1  synchronous, active-low reset
- RegWriteD  input  1  decode: register-file write enable
- ResultSrcD  input  2  decode: result select; 2'b01 = load
- MemWriteD  input  1  decode: store
- JumpD  input  1  decode: jal/jalr
- BranchD  input  1  decode: conditional branch
- ALUSrcD  input  1  decode: ALU B operand select
- ALUControlD  input  3  decode: ALU operation
- RD1_D, RD2_D  input  XLEN  decode: register-file read data
- Imm_Ext_D  input  XLEN  decode: extended immediate
- PCD, PCPlus4D  input  XLEN  decode: PC and PC+4
- Rs1_D, Rs2_D, RD_D  input  5  decode: source and destination register indices
- PCSrcE  input  1  execute: taken branch or jump this cycle
- RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE  output  1  E-stage control
- ResultSrcE  output  2  E-stage result select
- ALUControlE  output  3  E-stage ALU operation
- RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E  output  XLEN  E-stage data
- Rs1_E, Rs2_E, RD_E  output  5  E-stage register indices
- ValidE  output  1  E holds a real instruction (0 = bubble)
- StallF, StallD  output  1  hold the PC and the IF/ID register
- FlushD  output  1  clear the IF/ID register

Behaviour:
- All E outputs are registered and update on the rising clk edge. D->E latency is 1 cycle.
- Reset (rst==0 at an edge): all E outputs clear to 0, including ValidE. Reset applies mid-operation and overrides flush and stall.
- Combinational hazard terms, derived from registered E state and the current D inputs only:
  - lwStall = ValidE & (ResultSrcE==2'b01) & RegWriteE & (RD_E!=0) & ((RD_E==Rs1_D) | (RD_E==Rs2_D))
  - StallF = StallD = lwStall & ~PCSrcE
  - FlushD = PCSrcE
  - flushE = lwStall | PCSrcE
- While rst==0: StallF, StallD and FlushD are forced to 0.
- Edge update, in priority order:
  1. rst==0: clear everything.
  2. flushE: load a bubble. All control outputs go to 0, ValidE=0, Rs1_E/Rs2_E/RD_E=0, data fields=0. A bubble never writes and never matches forwarding (RD_E=0).
  3. Otherwise: capture all *_D inputs and set ValidE=1.
- No E-hold state exists: a load-use stall always resolves in exactly 1 cycle, because the next cycle's E holds the bubble and lwStall deasserts.
- lwStall with PCSrcE in the same cycle is architecturally impossible (a single instruction in E). If it occurs, PCSrcE wins: stalls are masked and the flush proceeds.
- x0 destination (RD_E==0) never causes a stall.

Optional Feature:
- Macro HAZARD_STATS_EN.
- Defined:
  - Adds outputs StallCnt and FlushCnt, each CNT_W bits.
  - StallCnt increments on each edge where lwStall & ~PCSrcE.
  - FlushCnt increments on each edge where PCSrcE.
  - Both saturate at all-ones and clear on reset.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset: hold rst=0 for 2 cycles with nonzero D inputs -> all E outputs 0, ValidE=0, StallF/StallD/FlushD=0. Release -> first D word appears on E after 1 edge with ValidE=1.
- Pass-through: D = {RegWriteD=1, ALUControlD=3'b010, Rs1_D=5, Rs2_D=6, RD_D=7, RD1_D=32'h1234} -> identical values on E one cycle later, no stall.
- Load-use: E holds lw x7 (ResultSrcE=01, RD_E=7); D has Rs2_D=7 -> StallF=StallD=1 for exactly 1 cycle, next E is a bubble (ValidE=0, RD_E=0), then the dependent instruction enters E.
- x0 load: lw x0 in E, Rs1_D=0 -> no stall.
- Taken branch: PCSrcE=1 -> FlushD=1 the same cycle, next E is a bubble, no stall asserted.
- With HAZARD_STATS_EN, CNT_W=2: 5 load-use stalls -> StallCnt=3 (saturated). 1 taken branch -> FlushCnt=1. Reset -> both 0.
